// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Frames are [header, CMD, DATA, CHK]; moves are one-hot codes for the LED stage.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    localparam logic [7:0] CMD_MOVE = 8'h01;
    localparam logic [7:0] CMD_CLR  = 8'h02;

    localparam logic [2:0] MOVE_NONE     = 3'b000;
    localparam logic [2:0] MOVE_ROCK     = 3'b001;
    localparam logic [2:0] MOVE_PAPER    = 3'b010;
    localparam logic [2:0] MOVE_SCISSORS = 3'b100;

    // Data values outside 1..3 keep whatever move was already shown.
    function automatic logic [2:0] move_code(input logic [7:0] data, input logic [2:0] cur);
        case (data)
            8'd1:    move_code = MOVE_ROCK;
            8'd2:    move_code = MOVE_PAPER;
            8'd3:    move_code = MOVE_SCISSORS;
            default: move_code = cur;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and frame/error outputs of the command parser.
// master = byte source (UART side / bench), slave = the parser.
interface uart_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_int;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_data;
    logic [2:0] move_onehot;
    logic       err_chk;
    logic       err_timeout;
    logic [7:0] err_cnt;

    modport master (
        output rx_data, rx_int,
        input  frame_valid, frame_cmd, frame_data, move_onehot,
        input  err_chk, err_timeout, err_cnt
    );

    modport slave (
        input  rx_data, rx_int,
        output frame_valid, frame_cmd, frame_data, move_onehot,
        output err_chk, err_timeout, err_cnt
    );

endinterface

// File: rtl/uart_cmd_parser_byte_strobe.sv
// Turns the receiver busy flag into a one-cycle strobe on its falling edge,
// which is the cycle in which rx_data holds the completed byte.
module uart_byte_strobe (
    input  logic clk,
    input  logic rst,
    input  logic rx_int,
    output logic byte_stb
);

    logic rx_int_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_int_d <= 1'b0;
        end else begin
            rx_int_d <= rx_int;
        end
    end

    assign byte_stb = rx_int_d & ~rx_int;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses [HDR, CMD, DATA, CHK] frames from the UART byte stream, publishes good
// frames and the current game move, and flags/counts checksum and stall errors.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter logic [7:0] CHK_SEED    = 8'h55,
    parameter int          TIMEOUT_CYC = 78125,
    parameter int          CNT_W       = 17
) (
    input logic              clk,
    input logic              rst,
    uart_cmd_parser_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic             byte_stb;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cmd_r;
    logic [7:0]       data_r;
    logic             good_frame;
    logic             bad_chk;
    logic             timeout_hit;

    logic             frame_valid_r;
    logic [7:0]       frame_cmd_r;
    logic [7:0]       frame_data_r;
    logic [2:0]       move_r;
    logic             err_chk_r;
    logic             err_timeout_r;
    logic [7:0]       err_cnt_r;

    uart_byte_strobe u_byte_strobe (
        .clk      (clk),
        .rst      (rst),
        .rx_int   (bus.rx_int),
        .byte_stb (byte_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte arriving on the last allowed cycle beats the timeout.
    always_comb begin
        state_nxt   = state;
        good_frame  = 1'b0;
        bad_chk     = 1'b0;
        timeout_hit = (state != ST_IDLE) && !byte_stb && (cnt == CNT_LAST);
        case (state)
            ST_IDLE: if (byte_stb && bus.rx_data == HDR_BYTE) state_nxt = ST_CMD;
            ST_CMD:  if (byte_stb) state_nxt = ST_DATA;
            ST_DATA: if (byte_stb) state_nxt = ST_CHK;
            ST_CHK: begin
                if (byte_stb) begin
                    state_nxt = ST_IDLE;
                    if (bus.rx_data == (cmd_r ^ data_r ^ CHK_SEED)) begin
                        good_frame = 1'b1;
                    end else begin
                        bad_chk = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_IDLE || byte_stb || timeout_hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r         <= 8'h00;
            data_r        <= 8'h00;
            frame_valid_r <= 1'b0;
            frame_cmd_r   <= 8'h00;
            frame_data_r  <= 8'h00;
            move_r        <= MOVE_NONE;
            err_chk_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            err_cnt_r     <= 8'h00;
        end else begin
            if (state == ST_CMD && byte_stb) cmd_r <= bus.rx_data;
            if (state == ST_DATA && byte_stb) data_r <= bus.rx_data;
            frame_valid_r <= good_frame;
            err_chk_r     <= bad_chk;
            err_timeout_r <= timeout_hit;
            if (good_frame) begin
                frame_cmd_r  <= cmd_r;
                frame_data_r <= data_r;
                if (cmd_r == CMD_MOVE) begin
                    move_r <= move_code(data_r, move_r);
                end else if (cmd_r == CMD_CLR) begin
                    move_r <= MOVE_NONE;
                end
            end
            if ((bad_chk || timeout_hit) && err_cnt_r != 8'hFF) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_cmd   = frame_cmd_r;
    assign bus.frame_data  = frame_data_r;
    assign bus.move_onehot = move_r;
    assign bus.err_chk     = err_chk_r;
    assign bus.err_timeout = err_timeout_r;
    assign bus.err_cnt     = err_cnt_r;

endmodule
